// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encodings,
// EX/MEM control bit positions and the packed control-output bundle.
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [5:0] NOOP_OP  = 6'b111111;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MEM_BRANCH_BIT = 0;
  localparam int MEM_READ_BIT   = 1;
  localparam int MEM_WRITE_BIT  = 2;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel;
  } ctrl_t;

  // Flush dominates write-enable, so idex_we stays high during a load-use bubble
  localparam ctrl_t CTRL_HOLD     = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_RESET    = ctrl_t'(8'b0000_1110);
  localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b1111_0000);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1111);
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b0011_0100);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs and pipeline control outputs between the datapath
// (master) and the controller (slave).
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic [2:0]  mem_m;
  logic        mem_eq;
  logic [31:0] mem_target;
  logic        dmem_ready;

  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        dmem_req;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        timeout_err;

  modport master (
    output id_rs, id_rt, ex_rd, ex_memread, mem_m, mem_eq, mem_target, dmem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush,
    input  pc_sel, pc_target, dmem_req, state, stall_cnt, timeout_err
  );

  modport slave (
    input  id_rs, id_rt, ex_rd, ex_memread, mem_m, mem_eq, mem_target, dmem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush,
    output pc_sel, pc_target, dmem_req, state, stall_cnt, timeout_err
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination feeds a source
// register of the instruction currently in decode.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_ex_rd != REG_ZERO);
  assign w_src_match  = (i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt);
  assign o_load_use   = i_ex_memread & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-wait FSM with timeout, branch flush and
// load-use bubble insertion, plus a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  localparam logic [15:0] LIMIT_C = 16'(WAIT_LIMIT);

  logic [1:0]  r_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_timeout_err;

  logic [1:0]  w_next_state;
  logic [15:0] w_next_wait;
  logic [15:0] w_wait_inc;
  logic        w_mem_access;
  logic        w_mem_ok;
  logic        w_branch;
  logic        w_load_use;
  logic        w_dmem_req;
  ctrl_t       w_ctrl;

  assign w_mem_access = bus.mem_m[MEM_READ_BIT] | bus.mem_m[MEM_WRITE_BIT];
  assign w_mem_ok     = ~w_mem_access | bus.dmem_ready;
  assign w_branch     = bus.mem_m[MEM_BRANCH_BIT] & bus.mem_eq;
  assign w_wait_inc   = r_wait_cnt + 16'd1;

  hazard_detect u_hazard_detect (
    .i_ex_memread (bus.ex_memread),
    .i_ex_rd      (bus.ex_rd),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .o_load_use   (w_load_use)
  );

  // Next-state and control-output decode; reset overrides the outputs last
  always_comb begin
    w_ctrl       = CTRL_HOLD;
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_dmem_req   = 1'b0;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        w_dmem_req = w_mem_access;
        if (!w_mem_ok) begin
          w_ctrl = CTRL_HOLD;
          if (r_state == ST_RUN) begin
            w_next_state = ST_MEM_WAIT;
            w_next_wait  = 16'd0;
          end else if (w_wait_inc >= LIMIT_C) begin
            w_next_state = ST_ERROR;
            w_next_wait  = w_wait_inc;
          end else begin
            w_next_state = ST_MEM_WAIT;
            w_next_wait  = w_wait_inc;
          end
        end else begin
          w_next_state = ST_RUN;
          w_next_wait  = 16'd0;
          if (w_branch) begin
            w_ctrl = CTRL_BRANCH;
          end else if (w_load_use) begin
            w_ctrl = CTRL_LOAD_USE;
          end else begin
            w_ctrl = CTRL_RUN;
          end
        end
      end
      ST_ERROR: begin
        w_ctrl       = CTRL_HOLD;
        w_next_state = ST_ERROR;
      end
      default: begin
        w_ctrl       = CTRL_HOLD;
        w_next_state = ST_ERROR;
      end
    endcase
    if (!rst) begin
      w_ctrl     = CTRL_RESET;
      w_dmem_req = 1'b0;
    end else begin
      w_dmem_req = w_dmem_req;
    end
  end

  // FSM state, wait/stall counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 16'd0;
      r_stall_cnt   <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
      if (w_next_state == ST_ERROR) begin
        r_timeout_err <= 1'b1;
      end
      if ((r_state != ST_ERROR) && !w_ctrl.pc_we && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_we       = w_ctrl.pc_we;
  assign bus.ifid_we     = w_ctrl.ifid_we;
  assign bus.idex_we     = w_ctrl.idex_we;
  assign bus.exmem_we    = w_ctrl.exmem_we;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.idex_flush  = w_ctrl.idex_flush;
  assign bus.exmem_flush = w_ctrl.exmem_flush;
  assign bus.pc_sel      = w_ctrl.pc_sel;
  assign bus.pc_target   = w_ctrl.pc_sel ? bus.mem_target : 32'h0000_0000;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.state       = r_state;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances (default and WAIT_LIMIT=4)
// share one stimulus stream.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_stall;

  pipeline_ctrl_if bus();
  pipeline_ctrl_if bus4();

  pipeline_ctrl #(.WAIT_LIMIT(255)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pipeline_ctrl #(.WAIT_LIMIT(4))   dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.id_rs      = bus.id_rs;
  assign bus4.id_rt      = bus.id_rt;
  assign bus4.ex_rd      = bus.ex_rd;
  assign bus4.ex_memread = bus.ex_memread;
  assign bus4.mem_m      = bus.mem_m;
  assign bus4.mem_eq     = bus.mem_eq;
  assign bus4.mem_target = bus.mem_target;
  assign bus4.dmem_ready = bus.dmem_ready;

  // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush, pc_sel}
  wire [7:0] w_ctl  = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we,
                       bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.pc_sel};
  wire [7:0] w_ctl4 = {bus4.pc_we, bus4.ifid_we, bus4.idex_we, bus4.exmem_we,
                       bus4.ifid_flush, bus4.idex_flush, bus4.exmem_flush, bus4.pc_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.id_rs      = 5'd0;
    bus.id_rt      = 5'd0;
    bus.ex_rd      = 5'd0;
    bus.ex_memread = 1'b0;
    bus.mem_m      = 3'b000;
    bus.mem_eq     = 1'b0;
    bus.mem_target = 32'h0000_0000;
    bus.dmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    bus.mem_m      = 3'b011;
    bus.mem_eq     = 1'b1;
    bus.mem_target = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'h0E) begin n_err++; $display("FAIL reset_ctl: got %h want %h", w_ctl, 8'h0E); end
    n_cmp++; if (bus.pc_target !== 32'h0) begin n_err++; $display("FAIL reset_pc_target: got %h want 0", bus.pc_target); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_dmem_req: got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus4.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus4.timeout_err); end
    step();
    rst = 1'b1;
    set_idle();
    exp_stall = 16'd0;
  endtask

  task automatic test_idle();
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL idle_ctl: got %h want %h", w_ctl, 8'hF0); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL idle_dmem_req: got %b want 0", bus.dmem_req); end
    step();
  endtask

  task automatic test_load_use();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; bus.id_rt = 5'd9;
    @(negedge clk);
    n_cmp++; if ((w_ctl & 8'hDF) !== 8'h14) begin n_err++; $display("FAIL loaduse_rs_ctl: got %h want %h (mask df)", w_ctl, 8'h14); end
    n_cmp++; if (bus.stall_cnt !== exp_stall) begin n_err++; $display("FAIL loaduse_stall_before: got %0d want %0d", bus.stall_cnt, exp_stall); end
    step();
    exp_stall = exp_stall + 16'd1;
    bus.ex_memread = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.stall_cnt !== exp_stall) begin n_err++; $display("FAIL loaduse_stall_after: got %0d want %0d", bus.stall_cnt, exp_stall); end
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL loaduse_released: got %h want %h", w_ctl, 8'hF0); end
    step();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7;
    @(negedge clk);
    n_cmp++; if ((w_ctl & 8'hDF) !== 8'h14) begin n_err++; $display("FAIL loaduse_rt_ctl: got %h want %h (mask df)", w_ctl, 8'h14); end
    step();
    exp_stall = exp_stall + 16'd1;
    bus.id_rt = 5'd4;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL loaduse_nomatch: got %h want %h", w_ctl, 8'hF0); end
    step();
    bus.ex_memread = 1'b0; bus.id_rs = 5'd7;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL loaduse_noload: got %h want %h", w_ctl, 8'hF0); end
    step();
    set_idle();
  endtask

  task automatic test_zero_reg();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rt = 5'd0; bus.id_rs = 5'd0;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL zero_reg_ctl: got %h want %h", w_ctl, 8'hF0); end
    step();
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus.stall_cnt !== exp_stall) begin n_err++; $display("FAIL zero_reg_stall: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_branch();
    step();
    bus.mem_m = 3'b001; bus.mem_eq = 1'b1; bus.mem_target = 32'h0000_0040;
    @(negedge clk);
    n_cmp++; if ((w_ctl & 8'h8F) !== 8'h8F) begin n_err++; $display("FAIL branch_ctl: got %h want %h (mask 8f)", w_ctl, 8'h8F); end
    n_cmp++; if (bus.pc_target !== 32'h0000_0040) begin n_err++; $display("FAIL branch_target: got %h want %h", bus.pc_target, 32'h40); end
    step();
    bus.mem_eq = 1'b0;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL branch_not_taken_ctl: got %h want %h", w_ctl, 8'hF0); end
    n_cmp++; if (bus.pc_target !== 32'h0) begin n_err++; $display("FAIL branch_not_taken_target: got %h want 0", bus.pc_target); end
    step();
    set_idle();
  endtask

  task automatic test_mem_wait();
    bus.mem_m = 3'b010; bus.dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (w_ctl !== 8'h00) begin n_err++; $display("FAIL memwait_ctl c%0d: got %h want 00", c, w_ctl); end
      n_cmp++; if (bus.state !== ((c == 0) ? 2'd0 : 2'd1)) begin n_err++; $display("FAIL memwait_state c%0d: got %0d", c, bus.state); end
      n_cmp++; if (bus.dmem_req !== 1'b1) begin n_err++; $display("FAIL memwait_req c%0d: got %b want 1", c, bus.dmem_req); end
      step();
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL memwait_ready_ctl: got %h want %h", w_ctl, 8'hF0); end
    step();
    set_idle();
    exp_stall = exp_stall + 16'd4;
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL memwait_back_run: got %0d want 0", bus.state); end
    n_cmp++; if (bus.stall_cnt !== exp_stall) begin n_err++; $display("FAIL memwait_stall: got %0d want %0d", bus.stall_cnt, exp_stall); end
    n_cmp++; if (bus4.stall_cnt !== exp_stall) begin n_err++; $display("FAIL memwait_stall4: got %0d want %0d", bus4.stall_cnt, exp_stall); end
    step();
  endtask

  task automatic test_simultaneous();
    bus.mem_m = 3'b011; bus.mem_eq = 1'b1; bus.mem_target = 32'h0000_1234; bus.dmem_ready = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    @(negedge clk);
    n_cmp++; if ((w_ctl & 8'h8F) !== 8'h8F) begin n_err++; $display("FAIL simul_ctl: got %h want %h (mask 8f)", w_ctl, 8'h8F); end
    n_cmp++; if (bus.pc_target !== 32'h0000_1234) begin n_err++; $display("FAIL simul_target: got %h want %h", bus.pc_target, 32'h1234); end
    step();
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'h00) begin n_err++; $display("FAIL simul_wait_ctl: got %h want 00", w_ctl); end
    n_cmp++; if (bus.pc_target !== 32'h0) begin n_err++; $display("FAIL simul_wait_target: got %h want 0", bus.pc_target); end
    step();
    exp_stall = exp_stall + 16'd1;
    set_idle();
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL simul_state: got %0d want 1", bus.state); end
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL simul_release_ctl: got %h want %h", w_ctl, 8'hF0); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.stall_cnt !== exp_stall) begin n_err++; $display("FAIL simul_stall: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_timeout();
    step();
    bus.mem_m = 3'b010; bus.dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    @(negedge clk);
    n_cmp++; if (bus4.state !== 2'd1) begin n_err++; $display("FAIL timeout_pre_state: got %0d want 1", bus4.state); end
    n_cmp++; if (bus4.timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_pre_err: got %b want 0", bus4.timeout_err); end
    step();
    exp_stall = exp_stall + 16'd5;
    @(negedge clk);
    n_cmp++; if (bus4.state !== 2'd2) begin n_err++; $display("FAIL timeout_state: got %0d want 2", bus4.state); end
    n_cmp++; if (bus4.timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", bus4.timeout_err); end
    n_cmp++; if ((w_ctl4 & 8'hF1) !== 8'h00) begin n_err++; $display("FAIL timeout_ctl: got %h want 00 (mask f1)", w_ctl4); end
    n_cmp++; if (bus4.dmem_req !== 1'b0) begin n_err++; $display("FAIL timeout_req: got %b want 0", bus4.dmem_req); end
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL timeout_default_state: got %0d want 1", bus.state); end
    step();
    set_idle();
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    n_cmp++; if (bus4.timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b want 1", bus4.timeout_err); end
    n_cmp++; if (bus4.state !== 2'd2) begin n_err++; $display("FAIL timeout_stay: got %0d want 2", bus4.state); end
    n_cmp++; if (bus4.stall_cnt !== exp_stall) begin n_err++; $display("FAIL timeout_stall_frozen: got %0d want %0d", bus4.stall_cnt, exp_stall); end
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL timeout_default_run: got %0d want 0", bus.state); end
    rst = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if (bus4.state !== 2'd0) begin n_err++; $display("FAIL timeout_rst_state: got %0d want 0", bus4.state); end
    n_cmp++; if (bus4.timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_rst_err: got %b want 0", bus4.timeout_err); end
    n_cmp++; if (bus4.stall_cnt !== 16'd0) begin n_err++; $display("FAIL timeout_rst_stall: got %0d want 0", bus4.stall_cnt); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset_midwait();
    bus.mem_m = 3'b010; bus.dmem_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd1) begin n_err++; $display("FAIL midwait_state: got %0d want 1", bus.state); end
    rst = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL midwait_rst_state: got %0d want 0", bus.state); end
    n_cmp++; if (w_ctl !== 8'h0E) begin n_err++; $display("FAIL midwait_rst_ctl: got %h want %h", w_ctl, 8'h0E); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL midwait_rst_req: got %b want 0", bus.dmem_req); end
    step();
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    n_cmp++; if (w_ctl !== 8'hF0) begin n_err++; $display("FAIL midwait_after_ctl: got %h want %h", w_ctl, 8'hF0); end
    n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL midwait_after_stall: got %0d want 0", bus.stall_cnt); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL midwait_after_state: got %0d want 0", bus.state); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_stall = 16'd0;
    rst = 1'b0;
    set_idle();
    test_reset();
    test_idle();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
